// File: rtl/ball_collision_detector_if.sv
// Collision interface between the pixel-scan side and the ball collision detector.
// The master side drives the scan position, the ball position and the per-pixel
// draw requests. The slave side (the detector) returns the collision pulses and the
// edge code.
interface ball_collision_detector_if;
  logic               startOfFrame;
  logic        [10:0] pixelX;
  logic        [10:0] pixelY;
  logic signed [10:0] ballTopLeftX;
  logic signed [10:0] ballTopLeftY;
  logic               ballDR;
  logic               bracketsDR;
  logic               obstacleDR;
  logic               bumperDR;
  logic               movingObstacleDR;
  logic               wormhole1DR;
  logic               wormhole2DR;
  logic               leftFlipperDR;
  logic               rightFlipperDR;

  logic               collisionBrackets;
  logic               collisionObstacle;
  logic               collisionBumper;
  logic               collisionMovingObstacle;
  logic               collisionWormhole1;
  logic               collisionWormhole2;
  logic               collisionLeftFlipper;
  logic               collisionRightFlipper;
  logic         [3:0] HitEdgeCode;

  modport master (
    output startOfFrame, pixelX, pixelY, ballTopLeftX, ballTopLeftY, ballDR,
           bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
           wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
    input  collisionBrackets, collisionObstacle, collisionBumper,
           collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
           collisionLeftFlipper, collisionRightFlipper, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, ballTopLeftX, ballTopLeftY, ballDR,
           bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
           wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
    output collisionBrackets, collisionObstacle, collisionBumper,
           collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
           collisionLeftFlipper, collisionRightFlipper, HitEdgeCode
  );
endinterface

// File: rtl/ball_collision_detector.sv
// Ball collision detector.
// During a frame it accumulates the overlaps between the ball and each scene object,
// and it records which ball edges were touched. On each startOfFrame it stages
// that frame's result. In the following cycle it issues one-cycle collision pulses
// and a HitEdgeCode that stays stable for the whole frame.
// Object index order in the internal vectors: 0 brackets, 1 obstacle, 2 bumper,
// 3 moving obstacle, 4 wormhole1, 5 wormhole2, 6 left flipper, 7 right flipper.
module ball_collision_detector #(
  parameter int BALL_WIDTH        = 16,
  parameter int BALL_HEIGHT       = 16,
  parameter int EDGE_MARGIN       = 4,
  parameter int WORMHOLE_COOLDOWN = 8
) (
  input logic                      clk,
  input logic                      resetN,
  ball_collision_detector_if.slave bus
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;

  localparam int W1 = 4;
  localparam int W2 = 5;
  // Wormholes teleport the ball rather than bounce it, so they contribute no edges.
  localparam logic [7:0] EDGE_OBJECTS = 8'b1100_1111;

  localparam logic signed [11:0] MARGIN       = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_START  = 12'(BALL_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_START = 12'(BALL_HEIGHT - EDGE_MARGIN);

  localparam int CW = $clog2(WORMHOLE_COOLDOWN + 1);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(WORMHOLE_COOLDOWN);

  logic [0:0]        state, nextState;
  logic [7:0]        objDR, pixelHit, hitAcc, stagedHit, reportHit, pulses;
  logic [3:0]        pixelEdge, edgeHit, edgeAcc, hitEdgeReg;
  logic signed [11:0] offX, offY;
  logic [CW-1:0]     cooldown;
  logic              wormBlocked, wormPulse;

  assign objDR = {bus.rightFlipperDR, bus.leftFlipperDR, bus.wormhole2DR, bus.wormhole1DR,
                  bus.movingObstacleDR, bus.bumperDR, bus.obstacleDR, bus.bracketsDR};

  // The pixel position is unsigned and the ball corner is signed. Both are widened to
  // 12 bits so that a ball lying partly off-screen still gives correct offsets.
  assign offX = $signed({1'b0, bus.pixelX}) - $signed({bus.ballTopLeftX[10], bus.ballTopLeftX});
  assign offY = $signed({1'b0, bus.pixelY}) - $signed({bus.ballTopLeftY[10], bus.ballTopLeftY});

  // Edge bands of the current pixel: bit3 left, bit2 top, bit1 right, bit0 bottom.
  assign pixelEdge = {offX < MARGIN, offY < MARGIN, offX >= RIGHT_START, offY >= BOTTOM_START};
  assign pixelHit  = bus.ballDR ? objDR : 8'h00;
  assign edgeHit   = (|(pixelHit & EDGE_OBJECTS)) ? pixelEdge : 4'h0;

  // Compute the frame result to stage. Wormholes are suppressed during cooldown,
  // and wormhole1 takes priority when both wormholes were hit.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    reportHit       = hitAcc;
    wormBlocked     = (cooldown != '0);
    reportHit[W1]   = hitAcc[W1] & ~wormBlocked;
    reportHit[W2]   = hitAcc[W2] & ~hitAcc[W1] & ~wormBlocked;
    wormPulse       = reportHit[W1] | reportHit[W2];
  end

  // Next-state logic. Any startOfFrame leads to a one-cycle REPORT, including back-to-back frames.
  always_comb begin
    nextState = state;
    case (state)
      ACCUM:   nextState = bus.startOfFrame ? REPORT : ACCUM;
      REPORT:  nextState = bus.startOfFrame ? REPORT : ACCUM;
      default: nextState = ACCUM;
    endcase
  end

  // State, accumulators, staging, and the wormhole cooldown counter.
  // NOTE: asynchronous active-low reset clears all state, so hits seen before reset never reach a report.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ACCUM;
      hitAcc     <= '0;
      edgeAcc    <= '0;
      stagedHit  <= '0;
      hitEdgeReg <= '0;
      cooldown   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the pre-edge values.
      state <= nextState;
      if (bus.startOfFrame) begin
        stagedHit  <= reportHit;
        hitEdgeReg <= edgeAcc;
        // A hit in the startOfFrame cycle belongs to the new frame.
        hitAcc     <= pixelHit;
        edgeAcc    <= edgeHit;
        if (wormPulse)
          cooldown <= COOLDOWN_LOAD;
        else if (cooldown != '0)
          cooldown <= cooldown - CW'(1);
      end else begin
        hitAcc  <= hitAcc | pixelHit;
        edgeAcc <= edgeAcc | edgeHit;
      end
    end
  end

  assign pulses = (state == REPORT) ? stagedHit : 8'h00;

  assign bus.collisionBrackets       = pulses[0];
  assign bus.collisionObstacle       = pulses[1];
  assign bus.collisionBumper         = pulses[2];
  assign bus.collisionMovingObstacle = pulses[3];
  assign bus.collisionWormhole1      = pulses[4];
  assign bus.collisionWormhole2      = pulses[5];
  assign bus.collisionLeftFlipper    = pulses[6];
  assign bus.collisionRightFlipper   = pulses[7];
  assign bus.HitEdgeCode             = hitEdgeReg;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Testbench for ball_collision_detector.
// The bench runs directed scenarios followed by random frames. A frame-level reference
// model predicts the pulses and the edge code, and both are compared on every cycle.
module tb_ball_collision_detector;
  logic clk;
  logic resetN;

  ball_collision_detector_if bus ();

  ball_collision_detector dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Reference model state. It tracks the set of objects hit in the current frame, the
  // edges touched, and the frame index of the last wormhole pulse.
  int         ballX, ballY;
  logic [7:0] modelHits;
  logic [3:0] modelEdges;
  logic [7:0] expPulse;
  logic [3:0] expEdge;
  int         frameIdx;
  int         lastWormFrame;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [7:0] observedPulses();
    return {bus.collisionRightFlipper, bus.collisionLeftFlipper, bus.collisionWormhole2,
            bus.collisionWormhole1, bus.collisionMovingObstacle, bus.collisionBumper,
            bus.collisionObstacle, bus.collisionBrackets};
  endfunction

  task automatic modelReset();
    modelHits     = '0;
    modelEdges    = '0;
    expPulse      = '0;
    expEdge       = '0;
    frameIdx      = 0;
    lastWormFrame = -1000;
  endtask

  task automatic modelStep(input logic sof, input int px, input int py, input logic bdr,
                           input logic [7:0] odr);
    logic [7:0] hits;
    logic [3:0] e;
    int ox, oy;
    hits = bdr ? odr : 8'h00;
    ox = px - ballX;
    oy = py - ballY;
    e = 4'h0;
    if (oy < 4)  e[2] = 1'b1;
    if (oy >= 12) e[0] = 1'b1;
    if (ox < 4)  e[3] = 1'b1;
    if (ox >= 12) e[1] = 1'b1;
    if ((hits & 8'hCF) == 8'h00) e = 4'h0;
    if (sof) begin
      frameIdx++;
      expPulse = modelHits;
      // Wormholes stay silent for 8 frames after any wormhole pulse.
      if (frameIdx - lastWormFrame <= 8) begin
        expPulse[4] = 1'b0;
        expPulse[5] = 1'b0;
      end
      if (expPulse[4]) expPulse[5] = 1'b0;
      if (expPulse[4] || expPulse[5]) lastWormFrame = frameIdx;
      expEdge    = modelEdges;
      modelHits  = hits;
      modelEdges = e;
    end else begin
      expPulse   = 8'h00;
      modelHits  = modelHits | hits;
      modelEdges = modelEdges | e;
    end
  endtask

  task automatic setBall(input int x, input int y);
    ballX = x;
    ballY = y;
    bus.ballTopLeftX = 11'(x);
    bus.ballTopLeftY = 11'(y);
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare just after it.
  task automatic cycle(input logic sof, input int px, input int py, input logic bdr,
                       input logic [7:0] odr);
    bus.startOfFrame     = sof;
    bus.pixelX           = 11'(px);
    bus.pixelY           = 11'(py);
    bus.ballDR           = bdr;
    bus.bracketsDR       = odr[0];
    bus.obstacleDR       = odr[1];
    bus.bumperDR         = odr[2];
    bus.movingObstacleDR = odr[3];
    bus.wormhole1DR      = odr[4];
    bus.wormhole2DR      = odr[5];
    bus.leftFlipperDR    = odr[6];
    bus.rightFlipperDR   = odr[7];
    @(posedge clk);
    if (!resetN) modelReset();
    else modelStep(sof, px, py, bdr, odr);
    #1;
    check("pulses", observedPulses(), expPulse);
    check("edgeCode", {4'h0, bus.HitEdgeCode}, {4'h0, expEdge});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 8'h00);
  endtask

  task automatic sof();
    cycle(1'b1, 0, 0, 1'b0, 8'h00);
  endtask

  initial begin
    resetN = 1'b0;
    modelReset();
    setBall(100, 200);
    idle(3);
    check("resetPulses", observedPulses(), 8'h00);
    check("resetEdge", {4'h0, bus.HitEdgeCode}, 8'h00);
    resetN = 1'b1;
    idle(2);

    // Bottom hit on brackets.
    cycle(1'b0, 108, 215, 1'b1, 8'h01);
    idle(3);
    sof();
    check("bottomPulse", observedPulses(), 8'h01);
    check("bottomEdge", {4'h0, bus.HitEdgeCode}, 8'h01);
    idle(4);
    check("bottomHold", {4'h0, bus.HitEdgeCode}, 8'h01);
    sof();
    check("bottomNoRepeat", observedPulses(), 8'h00);

    // Corner hit on bumper, then an empty frame.
    cycle(1'b0, 100, 200, 1'b1, 8'h04);
    idle(2);
    sof();
    check("cornerPulse", observedPulses(), 8'h04);
    check("cornerEdge", {4'h0, bus.HitEdgeCode}, 8'h0C);
    idle(3);
    sof();
    check("emptyEdge", {4'h0, bus.HitEdgeCode}, 8'h00);

    // Wormhole1 every frame for 10 frames.
    for (int f = 0; f < 10; f++) begin
      cycle(1'b0, 108, 208, 1'b1, 8'h10);
      idle(2);
      sof();
      check($sformatf("worm%0d", f), {7'h0, bus.collisionWormhole1},
            (f == 0 || f == 9) ? 8'h01 : 8'h00);
      check($sformatf("wormEdge%0d", f), {4'h0, bus.HitEdgeCode}, 8'h00);
    end

    // Two objects in one frame.
    cycle(1'b0, 115, 208, 1'b1, 8'h02);
    cycle(1'b0, 108, 215, 1'b1, 8'h40);
    idle(2);
    sof();
    check("simulPulses", observedPulses(), 8'h42);
    check("simulEdge", {4'h0, bus.HitEdgeCode}, 8'h03);

    // Hit in the SOF cycle belongs to the next frame.
    idle(2);
    cycle(1'b1, 108, 215, 1'b1, 8'h01);
    idle(1);
    sof();
    check("sofHitDeferred", observedPulses(), 8'h01);

    // Back-to-back SOF with a hit in the first SOF cycle.
    cycle(1'b0, 100, 210, 1'b1, 8'h08);
    cycle(1'b1, 112, 200, 1'b1, 8'h80);
    cycle(1'b1, 0, 0, 1'b0, 8'h00);
    idle(2);

    // Reset mid-frame discards accumulated hits.
    cycle(1'b0, 108, 215, 1'b1, 8'h01);
    resetN = 1'b0;
    idle(3);
    resetN = 1'b1;
    idle(2);
    sof();
    check("postResetPulses", observedPulses(), 8'h00);
    check("postResetEdge", {4'h0, bus.HitEdgeCode}, 8'h00);

    // Both wormholes in one frame: only wormhole1 pulses.
    cycle(1'b0, 105, 205, 1'b1, 8'h30);
    idle(1);
    sof();
    check("bothWorm", observedPulses(), 8'h10);

    // Ball partly off-screen.
    setBall(-5, -3);
    cycle(1'b0, 0, 0, 1'b1, 8'h02);
    cycle(1'b0, 5, 10, 1'b1, 8'h04);
    idle(1);
    sof();

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      setBall(int'($urandom_range(0, 608)) - 8, int'($urandom_range(0, 460)) - 8);
      for (int c = 0; c < 12; c++) begin
        int px, py;
        logic bdr;
        logic [7:0] odr;
        px  = ballX + int'($urandom_range(0, 15));
        py  = ballY + int'($urandom_range(0, 15));
        bdr = ($urandom_range(0, 3) != 0);
        odr = 8'h00;
        if ($urandom_range(0, 3) == 0) odr[$urandom_range(0, 7)] = 1'b1;
        if ($urandom_range(0, 7) == 0) odr[$urandom_range(0, 7)] = 1'b1;
        if (px < 0 || py < 0) begin
          px  = 0;
          py  = 0;
          bdr = 1'b0;
        end
        cycle(($urandom_range(0, 15) == 0), px, py, bdr, odr);
      end
      sof();
      if ($urandom_range(0, 4) == 0) sof();
    end

    idle(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ball_collision_detector.md
Name: ball_collision_detector

Overview:
- Producer side of the ball mover's collision interface.
- Scans the per-pixel draw requests during each frame and finds overlaps between the ball and each scene object (brackets, obstacle, bumper, moving obstacle, two wormholes, two flippers).
- Classifies each overlap by the ball edge it touches.
- Once per frame, issues one-cycle collision pulses plus a frame-stable HitEdgeCode to the mover.

Parameters:
- BALL_WIDTH, 16, ball sprite width in pixels.
- BALL_HEIGHT, 16, ball sprite height in pixels.
- EDGE_MARGIN, 4, depth in pixels of each edge band inside the ball box.
- WORMHOLE_COOLDOWN, 8, number of frames wormhole pulses stay suppressed after any wormhole pulse.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- pixelX  in  11  current scan pixel X, unsigned.
- pixelY  in  11  current scan pixel Y, unsigned.
- ballTopLeftX  in  11  ball position X, signed.
- ballTopLeftY  in  11  ball position Y, signed.
- ballDR  in  1  ball draw request at the current pixel.
- bracketsDR, obstacleDR, bumperDR, movingObstacleDR, wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR  in  1 each  object draw requests at the current pixel.
- collisionBrackets, collisionObstacle, collisionBumper, collisionMovingObstacle, collisionWormhole1, collisionWormhole2, collisionLeftFlipper, collisionRightFlipper  out  1 each  one-cycle collision pulses.
- HitEdgeCode  out  4  bit0 bottom, bit1 right, bit2 top, bit3 left.

Behaviour:
- Reset resetN, asynchronous, active-low; clock clk.
- On reset:
  - all collision outputs = 0; HitEdgeCode = 0.
  - accumulators cleared; state = ACCUM; cooldown counter = 0.
- Edge classification, per cycle:
  - offX = pixelX − ballTopLeftX and offY = pixelY − ballTopLeftY, both 12-bit signed.
  - top if offY < EDGE_MARGIN; bottom if offY ≥ BALL_HEIGHT − EDGE_MARGIN.
  - left if offX < EDGE_MARGIN; right if offX ≥ BALL_WIDTH − EDGE_MARGIN.
  - Corner pixels set two bits. Centre pixels set none.
- Hit qualification: a pixel is a hit for object k when ballDR && objDR_k in the same cycle.
  - Per-object sticky flag hitAcc[k] is set on a hit.
  - Edge bits are OR-ed into edgeAcc only for non-wormhole objects. Wormhole hits never set edge bits.
- State machine, two states:
  - ACCUM: accumulate hits. On startOfFrame go to REPORT.
    - In that same cycle, load the outputs staging registers from hitAcc/edgeAcc.
    - Then clear the accumulators and re-load them with that cycle's hit, if any. A hit pixel in the SOF cycle belongs to the new frame.
  - REPORT, exactly 1 cycle:
    - Drive each collision output = staged flag; HitEdgeCode = staged edges.
    - Return to ACCUM next cycle.
    - Pixel hits during REPORT accumulate normally.
- Output timing:
  - Collision pulses are high for exactly the one cycle after the startOfFrame cycle (latency 1), at most once per frame.
  - HitEdgeCode updates in that same cycle and holds until the next REPORT.
  - If no collidable object was hit in the previous frame, HitEdgeCode reports 0.
- Wormhole cooldown:
  - When either wormhole pulse is issued, the counter loads WORMHOLE_COOLDOWN.
  - The counter decrements by 1 on each startOfFrame while nonzero.
  - While the counter is nonzero at REPORT, both wormhole pulses are forced to 0. Their accumulators are still cleared.
  - If both wormholes were hit in one frame, only collisionWormhole1 pulses.
- startOfFrame arriving while in REPORT (back-to-back frames): treat it as a new SOF. Stay in REPORT one more cycle with the newly staged data.
- Ball partly off-screen (negative top-left): offsets are signed; classification still applies to on-screen pixels only.
- Reset asserted mid-frame: all accumulated hits are discarded. The first report after release reflects only pixels seen after release.

Test Plan:
- Bottom hit: ball at (100,200); pixel (108,215) with ballDR=1 and bracketsDR=1; then SOF → cycle after SOF collisionBrackets=1 for 1 cycle, HitEdgeCode=4'b0001, held until the next REPORT.
- Corner hit: same ball; pixel (100,200) with bumperDR=1; SOF → collisionBumper pulse, HitEdgeCode=4'b1100. Next frame with no hits → no pulse, HitEdgeCode=4'b0000.
- Wormhole cooldown: wormhole1DR overlap each frame for 10 frames → collisionWormhole1 pulses at frame 1 and frame 10 only (WORMHOLE_COOLDOWN=8). HitEdgeCode stays 0.
- Simultaneous objects: one frame contains an obstacle hit at (115,208) and a left-flipper hit at (108,215) → both pulses in the same cycle, HitEdgeCode=4'b0011.
- SOF-cycle hit: overlap driven exactly in the SOF cycle → no pulse at that frame's REPORT; pulse at the following SOF's REPORT.
- Reset mid-frame: hit accumulated, then resetN low for 3 cycles, then SOF → all outputs 0, no pulse.
